// File: rtl/opll_bus_sequencer.sv
// opll_bus_sequencer
//   Queues OPLL register writes and plays them out on the chip bus as an
//   address cycle (a0=0, din=register) followed by a data cycle (a0=1,
//   din=value), each padded by the chip's required recovery wait.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   ena                   advance enable for the bus sequencer (queue keeps accepting)
//   in_valid / in_ready   write request handshake, in_ready = queue not full
//   in_reg, in_data       register number and value
//   in_chip               target chip index (out-of-range -> silent bus cycle)
//   din, a0, cs_n, wr_n   registered chip bus
//   busy                  queue non-empty or a write in progress
//   fifo_level            entries currently queued
//
// state  | meaning
// IDLE   | bus quiet, waiting for a queued entry and ena
// SETUP  | cs_n/a0/din driven, wr_n high (1 cycle)
// PULSE  | wr_n low for PULSE_CYC cycles
// HOLD   | wr_n high, cs_n/a0/din held (1 cycle)
// WAIT   | all cs_n high, recovery time for the current phase
module opll_bus_sequencer #(
  parameter int NUM_CHIPS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PULSE_CYC  = 2,
  parameter int ADDR_WAIT  = 12,
  parameter int DATA_WAIT  = 84,
  localparam int CHIP_W    = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1,
  localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_reg,
  input  logic [7:0]           in_data,
  input  logic [CHIP_W-1:0]    in_chip,
  output logic [7:0]           din,
  output logic                 a0,
  output logic [NUM_CHIPS-1:0] cs_n,
  output logic                 wr_n,
  output logic                 busy,
  output logic [LVL_W-1:0]     fifo_level
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENT_W   = CHIP_W + 16;
  localparam int MAX_WT  = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int MAX_CNT = (PULSE_CYC > MAX_WT) ? PULSE_CYC : MAX_WT;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic PH_ADDR = 1'b0;
  localparam logic PH_DATA = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t               state;
  logic                 phase;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_CHIPS-1:0] cur_sel_n;
  logic [7:0]           cur_data;

  logic [ENT_W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [ENT_W-1:0]     head;
  logic                 empty;
  logic                 push;
  logic                 pop_go;
  logic                 wait_zero;
  logic [CNT_W-1:0]     wait_load;
  logic                 phase_end;

  function automatic logic [NUM_CHIPS-1:0] sel_n(input logic [CHIP_W-1:0] chip);
    logic [NUM_CHIPS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_CHIPS; i++) begin
      if (chip == CHIP_W'(i)) v[i] = 1'b0;
    end
    return v;
  endfunction

  assign head     = mem[rd_ptr];
  assign empty    = (fifo_level == '0);
  assign in_ready = (fifo_level != LVL_W'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign busy     = !empty || (state != S_IDLE);

  always_comb begin
    wait_zero = (phase == PH_DATA) ? (DATA_WAIT == 0) : (ADDR_WAIT == 0);
    wait_load = (phase == PH_DATA) ? CNT_W'(DATA_WAIT - 1) : CNT_W'(ADDR_WAIT - 1);
    // A zero recovery wait ends the phase straight out of HOLD.
    phase_end = ((state == S_HOLD) && wait_zero) || ((state == S_WAIT) && (cnt == '0));
    pop_go    = ena && !empty &&
                ((state == S_IDLE) || (phase_end && (phase == PH_DATA)));
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_chip, in_reg, in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_go) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop_go})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      phase     <= PH_ADDR;
      cnt       <= '0;
      cur_sel_n <= '1;
      cur_data  <= '0;
      din       <= '0;
      a0        <= 1'b0;
      cs_n      <= '1;
      wr_n      <= 1'b1;
    end else if (ena) begin
      if (pop_go) begin
        state     <= S_SETUP;
        phase     <= PH_ADDR;
        cur_sel_n <= sel_n(head[ENT_W-1 -: CHIP_W]);
        cur_data  <= head[7:0];
        cs_n      <= sel_n(head[ENT_W-1 -: CHIP_W]);
        a0        <= 1'b0;
        din       <= head[15:8];
        wr_n      <= 1'b1;
      end else if (phase_end) begin
        if (phase == PH_ADDR) begin
          state <= S_SETUP;
          phase <= PH_DATA;
          cs_n  <= cur_sel_n;
          a0    <= 1'b1;
          din   <= cur_data;
        end else begin
          state <= S_IDLE;
          cs_n  <= '1;
        end
      end else begin
        case (state)
          S_SETUP: begin
            state <= S_PULSE;
            cnt   <= CNT_W'(PULSE_CYC - 1);
            // Unselected (out-of-range) chip: keep the strobe high too.
            wr_n  <= &cs_n;
          end
          S_PULSE: begin
            if (cnt == '0) begin
              state <= S_HOLD;
              wr_n  <= 1'b1;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_HOLD: begin
            state <= S_WAIT;
            cnt   <= wait_load;
            cs_n  <= '1;
          end
          S_WAIT:  cnt <= cnt - CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_opll_bus_sequencer.sv
module tb_opll_bus_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  // main instance: 3 chips, default timing
  logic       ena, in_valid, in_ready, a0, wr_n, busy;
  logic [7:0] in_reg, in_data, din;
  logic [1:0] in_chip;
  logic [2:0] cs_n, fifo_level;

  // fast instance: 1 chip, 1-cycle pulse, no waits
  logic       f_ena, f_valid, f_ready, f_a0, f_wr_n, f_busy;
  logic [7:0] f_reg, f_data, f_din;
  logic [0:0] f_chip, f_cs_n;
  logic [2:0] f_level;

  opll_bus_sequencer #(.NUM_CHIPS(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg(in_reg), .in_data(in_data), .in_chip(in_chip), .din(din), .a0(a0),
    .cs_n(cs_n), .wr_n(wr_n), .busy(busy), .fifo_level(fifo_level)
  );

  opll_bus_sequencer #(.NUM_CHIPS(1), .PULSE_CYC(1), .ADDR_WAIT(0), .DATA_WAIT(0)) u_fast (
    .clk(clk), .rst_n(rst_n), .ena(f_ena), .in_valid(f_valid), .in_ready(f_ready),
    .in_reg(f_reg), .in_data(f_data), .in_chip(f_chip), .din(f_din), .a0(f_a0),
    .cs_n(f_cs_n), .wr_n(f_wr_n), .busy(f_busy), .fifo_level(f_level)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // bus monitor on the main instance
  logic [11:0] wlog[$];
  int   cs_multi = 0, cs_low_cyc = 0, bad_fall = 0, max_lvl = 0;
  logic prev_wr = 1'b1;

  always @(negedge clk) begin
    if (prev_wr && !wr_n) begin
      wlog.push_back({cs_n, a0, din});
      if (&cs_n) bad_fall++;
    end
    prev_wr = wr_n;
    if (cs_n != 3'b111) cs_low_cyc++;
    if ($countones(~cs_n) > 1) cs_multi++;
    if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
  end

  function automatic logic [11:0] log_at(input int i);
    if (i < wlog.size()) return wlog[i];
    return 12'hFFF;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] c, input logic [7:0] r, input logic [7:0] d);
    int g;
    g = 0;
    while (!in_ready && g < 1000) begin
      step(1);
      g++;
    end
    if (!in_ready) check_val("push_ready_timeout", in_ready, 1);
    in_chip  = c;
    in_reg   = r;
    in_data  = d;
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 2000) begin
      step(1);
      cyc++;
    end
    check_val("idle_reached", busy, 0);
  endtask

  initial begin
    int cyc, base, low0, n;
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_reg = '0; in_data = '0; in_chip = '0;
    f_ena = 1'b1; f_valid = 1'b0; f_reg = '0; f_data = '0; f_chip = '0;
    #12;
    check_val("rst_cs_n", cs_n, 3'b111);
    check_val("rst_wr_n", wr_n, 1);
    check_val("rst_din", din, 0);
    check_val("rst_a0", a0, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ready", in_ready, 1);
    check_val("rst_level", fifo_level, 0);
    check_val("rst_f_cs_n", f_cs_n, 1);
    rst_n = 1'b1;
    step(4);
    check_val("idle_busy", busy, 0);
    check_val("idle_wr_n", wr_n, 1);

    // single write, default timing
    push(2'd0, 8'h10, 8'hAB);
    check_val("t2_level_push", fifo_level, 1);
    check_val("t2_busy", busy, 1);
    step(1);
    check_val("t2_setup_cs", cs_n, 3'b110);
    check_val("t2_setup_a0", a0, 0);
    check_val("t2_setup_din", din, 8'h10);
    check_val("t2_setup_wr", wr_n, 1);
    check_val("t2_level_pop", fifo_level, 0);
    step(1);
    check_val("t2_pulse1", wr_n, 0);
    step(1);
    check_val("t2_pulse2", wr_n, 0);
    step(1);
    check_val("t2_hold_wr", wr_n, 1);
    check_val("t2_hold_cs", cs_n, 3'b110);
    step(1);
    check_val("t2_wait_cs", cs_n, 3'b111);
    check_val("t2_wait_din", din, 8'h10);
    step(12);
    check_val("t2_data_a0", a0, 1);
    check_val("t2_data_din", din, 8'hAB);
    check_val("t2_data_cs", cs_n, 3'b110);
    step(87);
    check_val("t2_busy_103", busy, 1);
    step(1);
    check_val("t2_busy_104", busy, 0);
    check_val("t2_end_cs", cs_n, 3'b111);
    check_val("t2_log_n", wlog.size(), 2);
    check_val("t2_log_addr", log_at(0), {3'b110, 1'b0, 8'h10});
    check_val("t2_log_data", log_at(1), {3'b110, 1'b1, 8'hAB});

    // five back-to-back pushes, alternating chips 0/1
    base = wlog.size();
    for (int k = 0; k < 5; k++) push(2'(k % 2), 8'h20 + 8'(k), 8'hA0 + 8'(k));
    check_val("t3_ready_full", in_ready, 0);
    check_val("t3_level_full", fifo_level, 4);
    wait_idle(cyc);
    check_val("t3_log_n", wlog.size() - base, 10);
    for (int k = 0; k < 5; k++) begin
      logic [2:0] s;
      s = (k % 2 == 1) ? 3'b101 : 3'b110;
      check_val($sformatf("t3_addr%0d", k), log_at(base + 2*k),     {s, 1'b0, 8'h20 + 8'(k)});
      check_val($sformatf("t3_data%0d", k), log_at(base + 2*k + 1), {s, 1'b1, 8'hA0 + 8'(k)});
    end
    check_val("t3_max_level", max_lvl, 4);
    check_val("t3_cs_multi", cs_multi, 0);
    check_val("t3_bad_fall", bad_fall, 0);

    // out-of-range chip index
    low0 = cs_low_cyc;
    push(2'd3, 8'h55, 8'h66);
    step(1);
    check_val("t4_busy", busy, 1);
    wait_idle(cyc);
    check_val("t4_cycles", cyc, 104);
    check_val("t4_no_cs", cs_low_cyc - low0, 0);

    // ena dropped for 10 cycles during the address pulse
    push(2'd2, 8'h77, 8'h88);
    step(1);
    check_val("t5_cs", cs_n, 3'b011);
    step(1);
    ena = 1'b0;
    step(10);
    check_val("t5_frozen_wr", wr_n, 0);
    check_val("t5_frozen_cs", cs_n, 3'b011);
    ena = 1'b1;
    wait_idle(cyc);
    check_val("t5_total", 11 + cyc, 114);
    check_val("t5_log_addr", log_at(wlog.size() - 2), {3'b011, 1'b0, 8'h77});
    check_val("t5_log_data", log_at(wlog.size() - 1), {3'b011, 1'b1, 8'h88});

    // zero-wait instance: 6-cycle entries, no idle gap
    f_chip = 1'b0; f_reg = 8'h31; f_data = 8'h32; f_valid = 1'b1;
    step(1);
    f_reg = 8'h41; f_data = 8'h42;
    step(1);
    f_valid = 1'b0;
    check_val("t7_addr_din", f_din, 8'h31);
    check_val("t7_addr_a0", f_a0, 0);
    check_val("t7_addr_cs", f_cs_n, 0);
    check_val("t7_level", f_level, 1);
    step(1);
    check_val("t7_pulse", f_wr_n, 0);
    step(2);
    check_val("t7_data_a0", f_a0, 1);
    check_val("t7_data_din", f_din, 8'h32);
    step(3);
    check_val("t7_next_din", f_din, 8'h41);
    check_val("t7_next_a0", f_a0, 0);
    check_val("t7_next_level", f_level, 0);
    check_val("t7_next_busy", f_busy, 1);
    step(6);
    check_val("t7_done_busy", f_busy, 0);
    check_val("t7_done_cs", f_cs_n, 1);

    // reset in the middle of a data pulse
    push(2'd1, 8'h90, 8'h91);
    push(2'd0, 8'h92, 8'h93);
    step(17);
    check_val("t6_pulse_wr", wr_n, 0);
    check_val("t6_pulse_a0", a0, 1);
    check_val("t6_pulse_din", din, 8'h91);
    check_val("t6_pulse_cs", cs_n, 3'b101);
    check_val("t6_pulse_level", fifo_level, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_rst_cs", cs_n, 3'b111);
    check_val("t6_rst_wr", wr_n, 1);
    check_val("t6_rst_level", fifo_level, 0);
    check_val("t6_rst_busy", busy, 0);
    check_val("t6_rst_din", din, 0);
    check_val("t6_rst_ready", in_ready, 1);
    #3 rst_n = 1'b1;
    n = wlog.size();
    step(30);
    check_val("t6_no_activity", wlog.size(), n);
    check_val("t6_after_busy", busy, 0);
    check_val("t6_after_wr", wr_n, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
